// File: rtl/aes_cmd_ctrl.sv
// AES command sequencer: assembles framed SET_KEY/ENCRYPT operands, pulses the core, streams out ciphertext.
// Latency: FIRE the cycle after the last operand word, SEND the cycle after the strobe; s_ready drops FIRE..SEND, m_data held while m_ready=0.
module aes_cmd_ctrl #(
   parameter int WORD_W    = 32,
   parameter int KEY_WORDS = 4,
   parameter int BLK_WORDS = 4,
   parameter int TIMEOUT   = 64,
   parameter logic [WORD_W-1:0] CMD_SET_KEY = WORD_W'(1),
   parameter logic [WORD_W-1:0] CMD_ENCRYPT = WORD_W'(2)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WORD_W-1:0]             s_data,
   input  logic                          s_valid,
   input  logic                          s_last,
   output logic                          s_ready,
   output logic [WORD_W-1:0]             m_data,
   output logic                          m_valid,
   output logic                          m_last,
   input  logic                          m_ready,
   output logic                          aes_en,
   output logic [WORD_W-1:0]             aes_cmd,
   output logic [KEY_WORDS*WORD_W-1:0]   aes_key,
   output logic [BLK_WORDS*WORD_W-1:0]   aes_plaintext,
   input  logic [BLK_WORDS*WORD_W-1:0]   aes_ciphertext,
   input  logic                          aes_en_o,
   output logic                          busy,
   output logic                          key_loaded,
   output logic [2:0]                    err
);

   localparam int KEY_W     = KEY_WORDS * WORD_W;
   localparam int BLK_W     = BLK_WORDS * WORD_W;
   localparam int MAX_WORDS = (KEY_WORDS > BLK_WORDS) ? KEY_WORDS : BLK_WORDS;
   localparam int SW        = (MAX_WORDS - 1) * WORD_W;
   localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WORDS - 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_WORDS - 1);
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_KEY, S_LOAD_BLK, S_FIRE, S_WAIT, S_SEND, S_DRAIN
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [TW-1:0]    tmo, tmo_nxt;
   logic             init_q;
   logic [SW-1:0]    stage;
   logic [BLK_W-1:0] out_q;
   logic             s_acc;
   logic             shift_in, commit_key, commit_blk, capture, shift_out;
   logic             key_set, key_clr;
   logic [CNT_W-1:0] last_idx;

   assign s_ready = ((state == S_IDLE) && init_q) || (state == S_LOAD_KEY) ||
                    (state == S_LOAD_BLK) || (state == S_DRAIN);
   assign s_acc   = s_valid && s_ready;
   assign aes_en  = (state == S_FIRE);
   assign busy    = (state != S_IDLE);
   assign m_valid = (state == S_SEND);
   assign m_last  = (state == S_SEND) && (cnt == BLK_LAST);
   assign m_data  = (state == S_SEND) ? out_q[BLK_W-1 -: WORD_W] : '0;
   assign last_idx = (state == S_LOAD_KEY) ? KEY_LAST : BLK_LAST;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      tmo_nxt    = tmo;
      err        = '0;
      shift_in   = 1'b0;
      commit_key = 1'b0;
      commit_blk = 1'b0;
      capture    = 1'b0;
      shift_out  = 1'b0;
      key_set    = 1'b0;
      key_clr    = 1'b0;
      case (state)
         S_IDLE: begin
            if (s_acc) begin
               cnt_nxt = '0;
               if (s_last) begin
                  err[1] = 1'b1;
               end else if (s_data == CMD_SET_KEY) begin
                  state_nxt = S_LOAD_KEY;
               end else if (s_data == CMD_ENCRYPT) begin
                  if (key_loaded) begin
                     state_nxt = S_LOAD_BLK;
                  end else begin
                     err[0]    = 1'b1;
                     state_nxt = S_DRAIN;
                  end
               end else begin
                  err[1]    = 1'b1;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_LOAD_KEY, S_LOAD_BLK: begin
            if (s_acc) begin
               if (cnt == last_idx) begin
                  cnt_nxt = '0;
                  if (s_last) begin
                     commit_key = (state == S_LOAD_KEY);
                     commit_blk = (state == S_LOAD_BLK);
                     state_nxt  = S_FIRE;
                  end else begin
                     err[1]    = 1'b1;
                     state_nxt = S_DRAIN;
                  end
               end else if (s_last) begin
                  // short frame: operands stay as they were
                  err[1]    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = S_IDLE;
               end else begin
                  shift_in = 1'b1;
                  cnt_nxt  = cnt + CNT_W'(1);
               end
            end
         end
         S_FIRE: begin
            tmo_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // a strobe on the final timeout cycle still wins
            if (aes_en_o) begin
               if (aes_cmd == CMD_SET_KEY) begin
                  key_set   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  capture   = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = S_SEND;
               end
            end else if (tmo == TMO_LAST) begin
               err[2]    = 1'b1;
               key_clr   = (aes_cmd == CMD_SET_KEY);
               state_nxt = S_IDLE;
            end else begin
               tmo_nxt = tmo + TW'(1);
            end
         end
         S_SEND: begin
            if (m_ready) begin
               shift_out = 1'b1;
               if (cnt == BLK_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = S_IDLE;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (s_acc && s_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         tmo    <= '0;
         init_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         tmo    <= tmo_nxt;
         init_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage         <= '0;
         aes_key       <= '0;
         aes_plaintext <= '0;
         aes_cmd       <= '0;
         out_q         <= '0;
         key_loaded    <= 1'b0;
      end else begin
         if (shift_in) stage <= (stage << WORD_W) | SW'(s_data);
         // the final word comes straight from the bus; earlier words from the stage
         if (commit_key) begin
            aes_key <= {stage[(KEY_WORDS-1)*WORD_W-1:0], s_data};
            aes_cmd <= CMD_SET_KEY;
         end
         if (commit_blk) begin
            aes_plaintext <= {stage[(BLK_WORDS-1)*WORD_W-1:0], s_data};
            aes_cmd       <= CMD_ENCRYPT;
         end
         if (capture) begin
            out_q <= aes_ciphertext;
         end else if (shift_out) begin
            out_q <= out_q << WORD_W;
         end
         if (key_set) begin
            key_loaded <= 1'b1;
         end else if (key_clr) begin
            key_loaded <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// Directed bench for aes_cmd_ctrl: framing, key/encrypt flow, stalls, timeout, mid-operation reset.
module tb_aes_cmd_ctrl;
   localparam int TIMEOUT = 64;
   localparam logic [31:0]  SET_KEY = 32'h1;
   localparam logic [31:0]  ENCRYPT = 32'h2;
   localparam logic [127:0] KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] KEY2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] PT   = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] CT   = 128'h3925841d_02dc09fb_dc118597_196a0b32;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  s_data;
   logic         s_valid, s_last, s_ready;
   logic [31:0]  m_data;
   logic         m_valid, m_last, m_ready;
   logic         aes_en;
   logic [31:0]  aes_cmd;
   logic [127:0] aes_key, aes_plaintext, aes_ciphertext;
   logic         aes_en_o, busy, key_loaded;
   logic [2:0]   err;

   int n_assert = 0;
   int n_fail   = 0;
   int en_cnt   = 0;

   aes_cmd_ctrl #(.WORD_W(32), .KEY_WORDS(4), .BLK_WORDS(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .aes_en(aes_en), .aes_cmd(aes_cmd), .aes_key(aes_key),
      .aes_plaintext(aes_plaintext), .aes_ciphertext(aes_ciphertext),
      .aes_en_o(aes_en_o), .busy(busy), .key_loaded(key_loaded), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (aes_en === 1'b1) en_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic word(input logic [31:0] d, input logic l, output logic [2:0] e);
      int n;
      n = 0;
      s_data = d; s_valid = 1'b1; s_last = l;
      #1;
      while (s_ready !== 1'b1 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 20) chk("s_ready_wait", s_ready, 1'b1);
      e = err;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
   endtask

   task automatic frame(input logic [31:0] cmd, input logic [127:0] op, output logic [2:0] e_or);
      logic [2:0]   e;
      logic [127:0] v;
      v = op;
      word(cmd, 1'b0, e);
      e_or = e;
      for (int i = 0; i < 4; i++) begin
         word(v[127-32*i -: 32], (i == 3), e);
         e_or |= e;
      end
   endtask

   task automatic strobe();
      aes_ciphertext = CT;
      aes_en_o = 1'b1;
      @(negedge clk);
      aes_en_o = 1'b0;
      aes_ciphertext = '0;
   endtask

   initial begin
      logic [2:0]   e;
      logic [127:0] ct_v;
      int           n;
      ct_v = CT;
      reset = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b0; aes_ciphertext = '0; aes_en_o = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_aes_en", aes_en, 1'b0);
      chk("rst_aes_cmd", aes_cmd, 32'h0);
      chk("rst_aes_key", aes_key, 128'h0);
      chk("rst_plaintext", aes_plaintext, 128'h0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_key_loaded", key_loaded, 1'b0);
      chk("rst_err", err, 3'b000);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      #1 chk("s_ready_first_cycle", s_ready, 1'b0);
      @(negedge clk);
      chk("s_ready_idle", s_ready, 1'b1);

      // ENCRYPT with no key loaded
      word(ENCRYPT, 1'b0, e);
      chk("nokey_err", e, 3'b001);
      chk("nokey_drain_busy", busy, 1'b1);
      chk("nokey_drain_ready", s_ready, 1'b1);
      word(32'h11111111, 1'b0, e);
      word(32'h22222222, 1'b0, e);
      word(32'h33333333, 1'b1, e);
      chk("nokey_drain_last_err", e, 3'b000);
      chk("nokey_idle", busy, 1'b0);
      chk("nokey_no_en", en_cnt, 0);
      chk("nokey_no_mvalid", m_valid, 1'b0);

      // framing errors
      word(SET_KEY, 1'b1, e);
      chk("cmd_last_err", e, 3'b010);
      chk("cmd_last_idle", busy, 1'b0);
      word(SET_KEY, 1'b0, e);
      word(32'h2b7e1516, 1'b0, e);
      word(32'h28aed2a6, 1'b1, e);
      chk("short_key_err", e, 3'b010);
      chk("short_key_idle", busy, 1'b0);
      chk("short_key_unchanged", aes_key, 128'h0);
      word(32'hdeadbeef, 1'b0, e);
      chk("bad_cmd_err", e, 3'b010);
      chk("bad_cmd_drain", busy, 1'b1);
      word(32'h44444444, 1'b1, e);
      chk("bad_cmd_idle", busy, 1'b0);

      // key load
      frame(SET_KEY, KEY, e);
      chk("key_frame_err", e, 3'b000);
      chk("key_fire_en", aes_en, 1'b1);
      chk("key_fire_cmd", aes_cmd, SET_KEY);
      chk("key_value", aes_key, KEY);
      @(negedge clk);
      chk("key_en_single", aes_en, 1'b0);
      chk("key_wait_ready", s_ready, 1'b0);
      repeat (3) @(negedge clk);
      aes_en_o = 1'b1;
      #1 chk("key_done_err", err, 3'b000);
      @(negedge clk);
      aes_en_o = 1'b0;
      chk("key_loaded", key_loaded, 1'b1);
      chk("key_done_idle", busy, 1'b0);
      chk("key_en_count", en_cnt, 1);

      // full-length key frame without s_last
      word(SET_KEY, 1'b0, e);
      for (int i = 0; i < 3; i++) word(32'h55555555, 1'b0, e);
      word(32'h66666666, 1'b0, e);
      chk("nolast_err", e, 3'b010);
      chk("nolast_drain", busy, 1'b1);
      word(32'h77777777, 1'b1, e);
      chk("nolast_idle", busy, 1'b0);
      chk("nolast_key_kept", aes_key, KEY);
      chk("nolast_no_en", en_cnt, 1);

      // encrypt with a stall mid-burst
      frame(ENCRYPT, PT, e);
      chk("enc_frame_err", e, 3'b000);
      chk("enc_fire_en", aes_en, 1'b1);
      chk("enc_fire_cmd", aes_cmd, ENCRYPT);
      chk("enc_plaintext", aes_plaintext, PT);
      chk("enc_key_stable", aes_key, KEY);
      repeat (3) @(negedge clk);
      strobe();
      for (int k = 0; k < 4; k++) begin
         chk("send_valid", m_valid, 1'b1);
         chk("send_data", m_data, ct_v[127-32*k -: 32]);
         chk("send_last", m_last, (k == 3));
         if (k == 1) begin
            repeat (5) begin
               @(negedge clk);
               chk("stall_valid", m_valid, 1'b1);
               chk("stall_data", m_data, ct_v[127-32*k -: 32]);
            end
         end
         m_ready = 1'b1;
         @(negedge clk);
         m_ready = 1'b0;
      end
      chk("send_done_valid", m_valid, 1'b0);
      chk("send_done_idle", busy, 1'b0);
      chk("send_done_ready", s_ready, 1'b1);
      chk("enc_en_count", en_cnt, 2);

      // stray strobe in IDLE
      aes_en_o = 1'b1;
      @(negedge clk);
      aes_en_o = 1'b0;
      chk("stray_busy", busy, 1'b0);
      chk("stray_valid", m_valid, 1'b0);

      // SET_KEY timeout
      frame(SET_KEY, KEY2, e);
      chk("tmo_fire_en", aes_en, 1'b1);
      chk("tmo_key", aes_key, KEY2);
      n = 0;
      while (err === 3'b000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, TIMEOUT);
      chk("tmo_err", err, 3'b100);
      @(negedge clk);
      chk("tmo_err_pulse", err, 3'b000);
      chk("tmo_key_cleared", key_loaded, 1'b0);
      chk("tmo_idle", busy, 1'b0);
      word(ENCRYPT, 1'b0, e);
      chk("tmo_then_nokey", e, 3'b001);
      word(32'h0, 1'b1, e);

      // reset during WAIT
      frame(SET_KEY, KEY, e);
      @(negedge clk);
      strobe();
      chk("reload_key", key_loaded, 1'b1);
      frame(ENCRYPT, PT, e);
      @(negedge clk);
      chk("wait_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("wrst_busy", busy, 1'b0);
      chk("wrst_key", aes_key, 128'h0);
      chk("wrst_pt", aes_plaintext, 128'h0);
      chk("wrst_cmd", aes_cmd, 32'h0);
      chk("wrst_key_loaded", key_loaded, 1'b0);
      chk("wrst_s_ready", s_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      strobe();
      chk("late_strobe_valid", m_valid, 1'b0);
      chk("late_strobe_busy", busy, 1'b0);

      // reset during SEND
      frame(SET_KEY, KEY, e);
      @(negedge clk);
      strobe();
      frame(ENCRYPT, PT, e);
      chk("srst_pt", aes_plaintext, PT);
      @(negedge clk);
      strobe();
      chk("srst_send_valid", m_valid, 1'b1);
      chk("srst_send_data", m_data, 32'h3925841d);
      reset = 1'b0;
      #1;
      chk("srst_m_valid", m_valid, 1'b0);
      chk("srst_m_data", m_data, 32'h0);
      chk("srst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      frame(SET_KEY, KEY2, e);
      chk("post_rst_err", e, 3'b000);
      chk("post_rst_en", aes_en, 1'b1);
      chk("post_rst_key", aes_key, KEY2);
      @(negedge clk);
      strobe();
      chk("post_rst_loaded", key_loaded, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/aes_cmd_ctrl.md
Name: aes_cmd_ctrl

Overview:
- Command sequencer in front of the AES core (key expansion + cipher + round-key SRAM).
- Accepts a word-wide input stream of framed commands (command word, then key or plaintext words) and assembles the wide operands.
- Issues single-cycle enable pulses to the core, waits for its completion strobe, and serialises ciphertext onto a word-wide output stream.
- Enforces ordering: no ENCRYPT before a successful SET_KEY; one operation in flight.

Parameters:
WORD_W, 32, stream word width (equals `WORD_S)
KEY_WORDS, 4, words per key (`KEY_S / WORD_W)
BLK_WORDS, 4, words per block (`BLK_S / WORD_W)
TIMEOUT, 64, max cycles from en pulse to core completion before abort

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
s_data  in  WORD_W  input stream word
s_valid  in  1  input word valid
s_last  in  1  final word of frame
s_ready  out  1  input word accepted when s_valid & s_ready
m_data  out  WORD_W  ciphertext word
m_valid  out  1  output word valid
m_last  out  1  final ciphertext word
m_ready  in  1  downstream accepts
aes_en  out  1  one-cycle start to core
aes_cmd  out  WORD_W  command to core (`SET_KEY / `ENCRYPT)
aes_key  out  `KEY_S  assembled key, held stable
aes_plaintext  out  `BLK_S  assembled block, held stable
aes_ciphertext  in  `BLK_S  core result
aes_en_o  in  1  core completion strobe
busy  out  1  high in every state except IDLE
key_loaded  out  1  a SET_KEY has completed since reset
err  out  3  one-cycle pulses: [0] no key, [1] bad frame/command, [2] timeout

Behaviour:
- Reset (reset=0, async): state IDLE; s_ready=0 for one cycle after reset release, then 1 in IDLE; m_valid=m_last=0; aes_en=0; aes_cmd, aes_key, aes_plaintext, m_data all zero; key_loaded=0; err=0; counters zero. Reset mid-operation abandons the frame; a late aes_en_o is ignored.
- Packing: first operand word goes to bits [0:WORD_W-1] (MSB end, codebase [0:N-1] order), word i to [i*WORD_W : (i+1)*WORD_W-1]. Output words are emitted in the same order.
- IDLE: s_ready=1. On accepted word: `SET_KEY -> LOAD_KEY; `ENCRYPT -> LOAD_BLK if key_loaded, else err[0] and DRAIN; other value -> err[1] and DRAIN. If s_last is set on the command word: err[1], stay IDLE.
- LOAD_KEY / LOAD_BLK: s_ready=1; word counter 0..N-1 (N = KEY_WORDS or BLK_WORDS). s_last before word N-1 -> err[1], IDLE, operand registers unchanged. Word N-1 without s_last -> err[1], DRAIN (no operation issued). Word N-1 with s_last -> FIRE.
- FIRE: s_ready=0; aes_en=1 for exactly one cycle with aes_cmd set; operands stable from FIRE until the next LOAD. -> WAIT, timeout counter cleared.
- WAIT: s_ready=0; counter increments each cycle. aes_en_o=1: SET_KEY -> key_loaded=1, IDLE (result discarded); ENCRYPT -> capture aes_ciphertext into output register, SEND. Counter reaching TIMEOUT-1 with no strobe -> err[2], key_loaded=0 on SET_KEY timeout, IDLE. A strobe arriving on the timeout cycle counts as completion.
- SEND: m_valid=1, m_data = word k; advance only on m_valid & m_ready; m_last=1 on k=BLK_WORDS-1; after the last handshake -> IDLE. m_data and m_valid held while stalled. s_ready=0 throughout.
- DRAIN: s_ready=1, discard words until one with s_last is accepted -> IDLE.
- aes_en_o outside WAIT is ignored.
- Throughput: at most one operation in flight; a new frame is accepted the cycle after SEND or WAIT completes.

Test Plan:
- Key load: frame {SET_KEY, 2b7e1516, 28aed2a6, abf71588, 09cf4f3c(last)} -> single aes_en pulse with aes_key=2b7e1516..09cf4f3c; key_loaded=1 after aes_en_o.
- Encrypt (FIPS-197 vector): after that key, frame {ENCRYPT, 3243f6a8, 885a308d, 313198a2, e0370734(last)} -> m_data 3925841d, 02dc09fb, dc118597, 196a0b32, m_last on the 4th word; hold m_ready=0 for 5 cycles mid-burst -> no word lost or duplicated.
- ENCRYPT directly after reset -> err[0] pulse, frame drained to s_last, no aes_en pulse, m_valid stays 0.
- Framing errors: key frame with s_last on word 2 -> err[1], IDLE; unknown command 0xdeadbeef -> err[1], drain; then a valid frame completes normally.
- Timeout: stub core never asserts aes_en_o -> err[2] exactly TIMEOUT cycles after aes_en; for SET_KEY, key_loaded=0.
- Reset asserted in WAIT and in SEND -> outputs return to reset values immediately; a late aes_en_o is ignored; next frame is processed correctly.
